// File: rtl/irq_controller.sv
`default_nettype none
// ============================================================================
// Module   : irq_controller
// Purpose  : Prioritising interrupt controller. It latches edge- or
//            level-triggered requests, applies a software mask, and presents
//            the lowest-index eligible source to the CPU. It tracks in-service
//            sources for nesting and issues a responder write after the CPU
//            accepts the external-interrupt source.
// Ports    : clk, reset        - clock, synchronous active-high reset
//            irq_src           - raw request lines (synchronous to clk)
//            cfg_we/addr/wdata - memory-mapped config write port
//            cfg_rdata         - combinational config read data
//            hwint             - registered PEND & MASK (CPU HWInt[7:2])
//            int_req/int_id    - registered request and winning source index
//            int_ack           - CPU handler-entry pulse
//            resp_valid/addr   - responder write request toward the Bridge
//            resp_ready        - Bridge accepted the responder write
// Revision : 1.0 - initial release
// ============================================================================
module irq_controller #(
    parameter int          NSRC      = 6,
    parameter int          EXT_SRC   = 2,
    parameter logic [31:0] BASE      = 32'h0000_7f30,
    parameter logic [31:0] RESP_ADDR = 32'h0000_7f20
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] irq_src,
    input  logic            cfg_we,
    input  logic [31:0]     cfg_addr,
    input  logic [31:0]     cfg_wdata,
    output logic [31:0]     cfg_rdata,
    output logic [NSRC-1:0] hwint,
    output logic            int_req,
    output logic [2:0]      int_id,
    input  logic            int_ack,
    output logic            resp_valid,
    output logic [31:0]     resp_addr,
    input  logic            resp_ready
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [NSRC-1:0] r_mask;
    logic [NSRC-1:0] r_edge;
    logic [NSRC-1:0] r_pend;
    logic [NSRC-1:0] r_insvc;
    logic [NSRC-1:0] r_src_q;
    logic [NSRC-1:0] r_hwint;
    logic            r_int_req;
    logic [2:0]      r_int_id;
    state_t          r_state;

    // ------------------------------------------------------------------------
    // Config decode
    // ------------------------------------------------------------------------
    logic            w_hit;
    logic [1:0]      w_sel;
    logic            w_wr_mask;
    logic            w_wr_edge;
    logic            w_wr_pend;
    logic            w_wr_insvc;
    logic            w_unused_bits;

    assign w_hit      = (cfg_addr[31:4] == BASE[31:4]);
    assign w_sel      = cfg_addr[3:2];
    assign w_wr_mask  = cfg_we & w_hit & (w_sel == 2'd0);
    assign w_wr_edge  = cfg_we & w_hit & (w_sel == 2'd1);
    assign w_wr_pend  = cfg_we & w_hit & (w_sel == 2'd2);
    assign w_wr_insvc = cfg_we & w_hit & (w_sel == 2'd3);

    // Byte-lane bits and upper data bits have no function in this block.
    assign w_unused_bits = ^{cfg_addr[1:0], cfg_wdata[31:NSRC]};

    always_comb begin
        cfg_rdata = 32'd0;
        if (w_hit) begin
            case (w_sel)
                2'd0:    cfg_rdata = {{(32-NSRC){1'b0}}, r_mask};
                2'd1:    cfg_rdata = {{(32-NSRC){1'b0}}, r_edge};
                2'd2:    cfg_rdata = {{(32-NSRC){1'b0}}, r_pend};
                default: cfg_rdata = {{(32-NSRC){1'b0}}, r_insvc};
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Acknowledge / EOI decode
    // ------------------------------------------------------------------------
    logic            w_ack;
    logic            w_ack_ext;
    logic [NSRC-1:0] w_ack_vec;
    logic [NSRC-1:0] w_eoi_vec;
    logic [NSRC-1:0] w_w1c;
    logic [NSRC-1:0] w_rise;
    logic [NSRC-1:0] w_pend_nxt;
    logic [NSRC-1:0] w_insvc_nxt;

    // An ack only counts while a request is actually being presented.
    assign w_ack     = int_ack & r_int_req;
    assign w_ack_ext = w_ack & (r_int_id == 3'(EXT_SRC));

    // EOI indices outside 0..NSRC-1 match no bit and are therefore ignored.
    always_comb begin
        w_ack_vec = '0;
        w_eoi_vec = '0;
        for (int i = 0; i < NSRC; i++) begin
            w_ack_vec[i] = w_ack & (r_int_id == 3'(i));
            w_eoi_vec[i] = w_wr_insvc & (cfg_wdata[2:0] == 3'(i));
        end
    end

    assign w_w1c  = w_wr_pend ? cfg_wdata[NSRC-1:0] : '0;
    assign w_rise = irq_src & ~r_src_q;

    // Edge bits: a fresh rising edge beats a same-cycle clear.
    // Level bits simply follow the input.
    assign w_pend_nxt  = (r_edge & ((r_pend & ~(w_w1c | w_ack_vec)) | w_rise))
                       | (~r_edge & irq_src);

    // Ack beats a same-cycle EOI of the same index.
    assign w_insvc_nxt = (r_insvc & ~w_eoi_vec) | w_ack_vec;

    // ------------------------------------------------------------------------
    // Eligibility: a source must sit strictly below every in-service bit,
    // i.e. no in-service bit at its own index or any lower index.
    // ------------------------------------------------------------------------
    logic [NSRC-1:0] w_blocked;
    logic [NSRC-1:0] w_elig;
    logic            w_found;
    logic [2:0]      w_win;

    assign w_blocked[0] = r_insvc[0];
    for (genvar g = 1; g < NSRC; g++) begin : g_blocked
        assign w_blocked[g] = w_blocked[g-1] | r_insvc[g];
    end

    assign w_elig = r_pend & r_mask & ~w_blocked;

    // Scan downward so the lowest eligible index is the last one written.
    always_comb begin
        w_found = 1'b0;
        w_win   = 3'd0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_found = 1'b1;
                w_win   = 3'(i);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Register update
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mask    <= '0;
            r_edge    <= '0;
            r_pend    <= '0;
            r_insvc   <= '0;
            r_src_q   <= '0;
            r_hwint   <= '0;
            r_int_req <= 1'b0;
            r_int_id  <= 3'd0;
        end else begin
            if (w_wr_mask) r_mask <= cfg_wdata[NSRC-1:0];
            if (w_wr_edge) r_edge <= cfg_wdata[NSRC-1:0];
            r_pend    <= w_pend_nxt;
            r_insvc   <= w_insvc_nxt;
            r_src_q   <= irq_src;
            r_hwint   <= r_pend & r_mask;
            // The accepted request is withdrawn for one cycle so the CPU
            // never sees a stale id while INSVC/PEND settle.
            r_int_req <= w_ack ? 1'b0 : w_found;
            r_int_id  <= w_win;
        end
    end

    // ------------------------------------------------------------------------
    // Responder FSM
    // ------------------------------------------------------------------------
    state_t w_state_nxt;
    logic   w_resp_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_resp_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_ack_ext) w_state_nxt = S_RESP;
            end
            S_RESP: begin
                w_resp_valid = 1'b1;
                // Only one responder write is outstanding; a new ext ack
                // arriving with the handshake keeps the request up.
                if (resp_ready && !w_ack_ext) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign hwint      = r_hwint;
    assign int_req    = r_int_req;
    assign int_id     = r_int_id;
    assign resp_valid = w_resp_valid;
    assign resp_addr  = w_resp_valid ? RESP_ADDR : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_irq_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_controller
// Purpose  : Self-checking bench for irq_controller: directed scenarios plus
//            a randomized phase, all checked every cycle against a
//            behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_irq_controller;

    localparam int          NSRC  = 6;
    localparam int          EXT   = 2;
    localparam logic [31:0] BASE  = 32'h0000_7f30;
    localparam logic [31:0] RADDR = 32'h0000_7f20;

    logic              clk = 1'b0;
    logic              reset;
    logic [NSRC-1:0]   irq_src;
    logic              cfg_we;
    logic [31:0]       cfg_addr;
    logic [31:0]       cfg_wdata;
    logic [31:0]       cfg_rdata;
    logic [NSRC-1:0]   hwint;
    logic              int_req;
    logic [2:0]        int_id;
    logic              int_ack;
    logic              resp_valid;
    logic [31:0]       resp_addr;
    logic              resp_ready;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state (plain integers, one bit per source)
    int m_mask, m_edge, m_pend, m_insvc, m_srcq, m_hw;
    int m_req, m_id, m_resp;

    irq_controller #(
        .NSRC     (NSRC),
        .EXT_SRC  (EXT),
        .BASE     (BASE),
        .RESP_ADDR(RADDR)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .irq_src   (irq_src),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .hwint     (hwint),
        .int_req   (int_req),
        .int_id    (int_id),
        .int_ack   (int_ack),
        .resp_valid(resp_valid),
        .resp_addr (resp_addr),
        .resp_ready(resp_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int bitof(input int v, input int i);
        return (v >> i) & 1;
    endfunction

    function automatic int model_rdata(input logic [31:0] a);
        if (a[31:4] != BASE[31:4]) return 0;
        case (a[3:2])
            2'd0:    return m_mask;
            2'd1:    return m_edge;
            2'd2:    return m_pend;
            default: return m_insvc;
        endcase
    endfunction

    // Advance the model by one clock using the inputs present at the edge.
    task automatic model_edge();
        int  acc, hit, sel, lowest, best, idx;
        int  n_pend, n_insvc;
        if (reset) begin
            m_mask = 0; m_edge = 0; m_pend = 0; m_insvc = 0; m_srcq = 0;
            m_hw = 0; m_req = 0; m_id = 0; m_resp = 0;
            return;
        end
        acc = (int_ack && m_req) ? 1 : 0;
        hit = (cfg_we && cfg_addr[31:4] == BASE[31:4]) ? 1 : 0;
        sel = int'(cfg_addr[3:2]);

        n_pend = 0;
        for (int i = 0; i < NSRC; i++) begin
            int b;
            if (bitof(m_edge, i) == 1) begin
                b = bitof(m_pend, i);
                if ((hit == 1 && sel == 2 && cfg_wdata[i]) || (acc == 1 && m_id == i)) b = 0;
                if (irq_src[i] && bitof(m_srcq, i) == 0) b = 1;
            end else begin
                b = irq_src[i] ? 1 : 0;
            end
            n_pend |= b << i;
        end

        n_insvc = m_insvc;
        idx = int'(cfg_wdata[2:0]);
        if (hit == 1 && sel == 3 && idx < NSRC) n_insvc &= ~(1 << idx);
        if (acc == 1) n_insvc |= (1 << m_id);

        lowest = NSRC;
        for (int i = NSRC - 1; i >= 0; i--) if (bitof(m_insvc, i) == 1) lowest = i;
        best = -1;
        for (int i = 0; i < lowest; i++)
            if (best < 0 && bitof(m_pend & m_mask, i) == 1) best = i;

        if (m_resp == 0) begin
            if (acc == 1 && m_id == EXT) m_resp = 1;
        end else if (resp_ready && !(acc == 1 && m_id == EXT)) begin
            m_resp = 0;
        end

        m_hw  = m_pend & m_mask;
        m_req = (acc == 0 && best >= 0) ? 1 : 0;
        m_id  = (best >= 0) ? best : 0;
        if (hit == 1 && sel == 0) m_mask = int'(cfg_wdata[NSRC-1:0]);
        if (hit == 1 && sel == 1) m_edge = int'(cfg_wdata[NSRC-1:0]);
        m_pend  = n_pend;
        m_insvc = n_insvc;
        m_srcq  = int'(irq_src);
    endtask

    task automatic check_all();
        chk("int_req", int_req, m_req);
        if (m_req == 1) chk("int_id", int_id, m_id);
        chk("hwint", hwint, m_hw);
        chk("resp_valid", resp_valid, m_resp);
        chk("resp_addr", resp_addr, (m_resp == 1) ? RADDR : 32'd0);
        chk("cfg_rdata", cfg_rdata, model_rdata(cfg_addr));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic wr(input logic [3:0] off, input logic [31:0] data);
        cfg_we    = 1'b1;
        cfg_addr  = BASE + 32'(off);
        cfg_wdata = data;
        step();
        cfg_we    = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] off, input logic [31:0] exp);
        cfg_addr = BASE + 32'(off);
        #1;
        chk(tag, cfg_rdata, exp);
    endtask

    initial begin
        reset = 1'b1; irq_src = '0; cfg_we = 1'b0; cfg_addr = BASE;
        cfg_wdata = '0; int_ack = 1'b0; resp_ready = 1'b0;
        step(); step();
        chk("rst int_req", int_req, 0);
        chk("rst hwint", hwint, 0);
        chk("rst resp_valid", resp_valid, 0);
        for (int k = 0; k < 4; k++) rd_chk("rst reg", 4'(k * 4), 0);
        reset = 1'b0;
        step();

        // Edge-triggered source 0
        wr(4'h0, 32'h01);
        wr(4'h4, 32'h01);
        irq_src[0] = 1'b1;
        step();
        chk("t1 lat1", int_req, 0);
        irq_src[0] = 1'b0;
        step();
        chk("t1 req", int_req, 1);
        chk("t1 id", int_id, 0);
        step(); step();
        chk("t1 hold", int_req, 1);
        int_ack = 1'b1;
        step();
        int_ack = 1'b0;
        chk("t1 ackdrop", int_req, 0);
        rd_chk("t1 insvc", 4'hC, 32'h01);
        wr(4'hC, 32'h0);

        // Masked level source 1
        wr(4'h4, 32'h0);
        wr(4'h0, 32'h0);
        irq_src = 6'b000010;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t2 masked", int_req, 0);
        end
        rd_chk("t2 pend", 4'h8, 32'h02);
        wr(4'h0, 32'h02);
        chk("t2 pre", int_req, 0);
        step();
        chk("t2 req", int_req, 1);
        chk("t2 id", int_id, 1);
        irq_src = '0;
        step(); step(); step();

        // Nesting
        wr(4'h0, 32'h3F);
        irq_src = 6'b001000;
        step(); step();
        chk("t3 req3", int_id, 3);
        int_ack = 1'b1; irq_src = '0;
        step();
        int_ack = 1'b0;
        irq_src = 6'b100000;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t3 blk5", int_req, 0);
        end
        irq_src = 6'b100010;
        step(); step();
        chk("t3 req1", int_req, 1);
        chk("t3 id1", int_id, 1);
        int_ack = 1'b1;
        step();
        int_ack = 1'b0;
        irq_src = 6'b100000;
        wr(4'hC, 32'h1);
        chk("t3 still", int_req, 0);
        wr(4'hC, 32'h3);
        chk("t3 still2", int_req, 0);
        step();
        chk("t3 req5", int_req, 1);
        chk("t3 id5", int_id, 5);
        irq_src = '0;
        step(); step(); step();

        // Responder
        resp_ready = 1'b0;
        irq_src = 6'b000100;
        step(); step();
        chk("t4 id2", int_id, 2);
        int_ack = 1'b1; irq_src = '0;
        step();
        int_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("t4 valid", resp_valid, 1);
            chk("t4 addr", resp_addr, 32'h7f20);
            step();
        end
        chk("t4 valid4", resp_valid, 1);
        resp_ready = 1'b1;
        step();
        chk("t4 done", resp_valid, 0);
        chk("t4 addr0", resp_addr, 0);
        resp_ready = 1'b0;
        wr(4'hC, 32'h2);

        // Simultaneous events: edge vs W1C, ack vs EOI
        wr(4'h4, 32'h01);
        wr(4'h0, 32'h00);
        irq_src[0] = 1'b1;
        wr(4'h8, 32'h01);
        rd_chk("t5 pend", 4'h8, 32'h01);
        irq_src = '0;
        wr(4'h8, 32'h01);
        rd_chk("t5 w1c", 4'h8, 32'h00);
        wr(4'h4, 32'h00);
        wr(4'h0, 32'h01);
        irq_src = 6'b000001;
        step(); step();
        chk("t5 req0", int_req, 1);
        int_ack = 1'b1;
        cfg_we = 1'b1; cfg_addr = BASE + 32'hC; cfg_wdata = 32'h0;
        step();
        int_ack = 1'b0; cfg_we = 1'b0;
        #1;
        chk("t5 insvc", cfg_rdata, 32'h01);
        irq_src = '0;
        wr(4'hC, 32'h0);
        step();

        // Reset mid-operation
        wr(4'h0, 32'h3C);
        irq_src = 6'h3F;
        resp_ready = 1'b0;
        step(); step();
        chk("t6 id2", int_id, 2);
        int_ack = 1'b1;
        step();
        int_ack = 1'b0;
        chk("t6 valid", resp_valid, 1);
        rd_chk("t6 pend", 4'h8, 32'h3F);
        reset = 1'b1;
        step();
        chk("t6 req", int_req, 0);
        chk("t6 hwint", hwint, 0);
        chk("t6 valid0", resp_valid, 0);
        chk("t6 addr", resp_addr, 0);
        for (int k = 0; k < 4; k++) rd_chk("t6 reg", 4'(k * 4), 0);
        reset = 1'b0;
        irq_src = '0;
        step(); step();

        // Randomized phase
        for (int c = 0; c < 3000; c++) begin
            int r, off;
            if ($urandom_range(0, 3) == 0) begin
                int k;
                k = $urandom_range(0, NSRC - 1);
                irq_src[k] = ~irq_src[k];
            end
            int_ack    = ((m_req == 1) && ($urandom_range(0, 1) == 1)) || ($urandom_range(0, 15) == 0);
            resp_ready = ($urandom_range(0, 2) == 0);
            reset      = ($urandom_range(0, 299) == 0);
            r   = $urandom_range(0, 9);
            off = $urandom_range(0, 3);
            if (r < 3) begin
                cfg_we    = 1'b1;
                cfg_addr  = ($urandom_range(0, 15) == 0) ? BASE + 32'h40 : BASE + 32'(off * 4);
                cfg_wdata = (off == 3) ? 32'($urandom_range(0, 7)) : $urandom;
            end else begin
                cfg_we   = 1'b0;
                cfg_addr = ($urandom_range(0, 7) == 0) ? $urandom : BASE + 32'(off * 4);
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
